// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared types and constants for the sequential InvMixColumns block.
// GF(2^8) helpers (poly 0x11B) used by the shared column unit.
package inv_mix_columns_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } imc_state_e;

    localparam int unsigned ColCntW = 2;
    localparam int unsigned StateW  = 128;
    localparam int unsigned ColW    = 32;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant: sum of a, 2a, 4a, 8a selected by k.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return (k[0] ? a  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_column_unit.sv
// Combinational InvMixColumns on one 32-bit column; row 0 byte is the MSB.
module inv_mix_column_unit
    import inv_mix_columns_seq_pkg::*;
(
    input  logic [ColW-1:0] col_in,
    output logic [ColW-1:0] col_out
);

    logic [7:0] b0, b1, b2, b3;
    logic [7:0] r0, r1, r2, r3;

    assign b0 = col_in[31:24];
    assign b1 = col_in[23:16];
    assign b2 = col_in[15:8];
    assign b3 = col_in[7:0];

    assign r0 = gf_mul(b0, 4'he) ^ gf_mul(b1, 4'hb) ^ gf_mul(b2, 4'hd) ^ gf_mul(b3, 4'h9);
    assign r1 = gf_mul(b0, 4'h9) ^ gf_mul(b1, 4'he) ^ gf_mul(b2, 4'hb) ^ gf_mul(b3, 4'hd);
    assign r2 = gf_mul(b0, 4'hd) ^ gf_mul(b1, 4'h9) ^ gf_mul(b2, 4'he) ^ gf_mul(b3, 4'hb);
    assign r3 = gf_mul(b0, 4'hb) ^ gf_mul(b1, 4'hd) ^ gf_mul(b2, 4'h9) ^ gf_mul(b3, 4'he);

    assign col_out = {r0, r1, r2, r3};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns: one shared column unit, one column per cycle.
// Optional IMC_BYPASS_EN adds in_bypass, which sends a state straight to DONE unchanged.
module inv_mix_columns_seq
    import inv_mix_columns_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [StateW-1:0] in_state,
`ifdef IMC_BYPASS_EN
    input  logic              in_bypass,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [StateW-1:0] out_state,
    output logic              busy
);

    imc_state_e          state_q, state_d;
    logic [ColCntW-1:0]  col_cnt_q, col_cnt_d;
    logic [StateW-1:0]   work_q, work_d;
    logic [ColW-1:0]     col_in, col_out;

    // Column c lives at bits [127-32c -: 32].
    always_comb begin
        col_in = work_q[StateW-1 -: ColW];
        case (col_cnt_q)
            2'd0:    col_in = work_q[StateW-1 -: ColW];
            2'd1:    col_in = work_q[StateW-1-ColW -: ColW];
            2'd2:    col_in = work_q[StateW-1-2*ColW -: ColW];
            default: col_in = work_q[ColW-1:0];
        endcase
    end

    inv_mix_column_unit u_col (
        .col_in  (col_in),
        .col_out (col_out)
    );

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        work_d    = work_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    work_d    = in_state;
                    col_cnt_d = '0;
`ifdef IMC_BYPASS_EN
                    state_d   = in_bypass ? StDone : StRun;
`else
                    state_d   = StRun;
`endif
                end
            end
            StRun: begin
                case (col_cnt_q)
                    2'd0:    work_d[StateW-1 -: ColW]        = col_out;
                    2'd1:    work_d[StateW-1-ColW -: ColW]   = col_out;
                    2'd2:    work_d[StateW-1-2*ColW -: ColW] = col_out;
                    default: work_d[ColW-1:0]                = col_out;
                endcase
                col_cnt_d = col_cnt_q + 2'd1;
                if (col_cnt_q == 2'd3) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            col_cnt_q <= '0;
            work_q    <= '0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            work_q    <= work_d;
        end
    end

    assign out_state = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed self-checking bench for inv_mix_columns_seq (vector table plus handshake corners).
module tb_inv_mix_columns_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
`ifdef IMC_BYPASS_EN
    logic         in_bypass;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    inv_mix_columns_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
`ifdef IMC_BYPASS_EN
        .in_bypass (in_bypass),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the accept edge until out_valid is seen; 99 if it never comes.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    task automatic run_vec(input string name, input logic [127:0] din, input logic [127:0] dout);
        int lat;
        in_valid  = 1'b1;
        in_state  = din;
        out_ready = 1'b1;
        check({name, " in_ready"}, 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        wait_out(lat);
        check({name, " latency"}, 128'(lat), 128'(5));
        check({name, " out_state"}, out_state, dout);
        step();
        check({name, " pulse"}, 128'(out_valid), 128'(0));
    endtask

    initial begin
        int lat;
        logic ok;
        logic [127:0] held;

        vecs[0] = '{din: 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                    dout: 128'hdb135345_f20a225c_01010101_c6c6c6c6};
        vecs[1] = '{din: 128'hd5d5d7d6_4d7ebdf8_c6c6c6c6_01010101,
                    dout: 128'hd4d4d4d5_2d26314c_c6c6c6c6_01010101};
        vecs[2] = '{din: 128'h046681e5_e0cb199a_48f8d37a_2806264c,
                    dout: 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
        vecs[3] = '{din: 128'h0, dout: 128'h0};
        vecs[4] = '{din: {128{1'b1}}, dout: {128{1'b1}}};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b0;
`ifdef IMC_BYPASS_EN
        in_bypass = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        check("rst in_ready", 128'(in_ready), 128'(1));
        check("rst busy", 128'(busy), 128'(0));
        check("rst out_valid", 128'(out_valid), 128'(0));
        check("rst out_state", out_state, 128'h0);

        // out_ready while idle is harmless
        out_ready = 1'b1;
        step();
        check("idle out_ready", 128'(out_valid), 128'(0));

        for (int i = 0; i < 5; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].din, vecs[i].dout);
        end

        // Backpressure, then back-to-back acceptance of a held second state
        in_valid  = 1'b1;
        in_state  = vecs[0].din;
        out_ready = 1'b0;
        step();
        check("bp busy run", 128'(busy), 128'(1));
        in_state = vecs[1].din;
        wait_out(lat);
        check("bp latency", 128'(lat), 128'(5));
        held = out_state;
        check("bp first result", held, vecs[0].dout);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!out_valid || out_state !== held || in_ready) ok = 1'b0;
        end
        check("bp hold 10 cycles", 128'(ok), 128'(1));
        out_ready = 1'b1;
        step();
        check("bp release idle", 128'(in_ready), 128'(1));
        check("bp release valid", 128'(out_valid), 128'(0));
        step();
        in_valid = 1'b0;
        check("b2b accepted", 128'(busy), 128'(1));
        wait_out(lat);
        check("b2b latency", 128'(lat), 128'(5));
        check("b2b result", out_state, vecs[1].dout);
        step();

        // Reset while col_cnt == 2
        in_valid = 1'b1;
        in_state = vecs[2].din;
        step();
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrun rst in_ready", 128'(in_ready), 128'(1));
        check("midrun rst busy", 128'(busy), 128'(0));
        check("midrun rst state", out_state, 128'h0);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) ok = 1'b0;
            step();
        end
        check("midrun rst no valid", 128'(ok), 128'(1));

`ifdef IMC_BYPASS_EN
        in_valid  = 1'b1;
        in_bypass = 1'b1;
        in_state  = 128'h00112233_44556677_8899aabb_ccddeeff;
        step();
        in_valid  = 1'b0;
        in_bypass = 1'b0;
        check("byp valid T+1", 128'(out_valid), 128'(1));
        check("byp out_state", out_state, 128'h00112233_44556677_8899aabb_ccddeeff);
        step();
        run_vec("byp0", vecs[0].din, vecs[0].dout);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
